// File: rtl/deser_queue_if.sv
// -----------------------------------------------------------------------------
// deser_queue_if
//   Bus bundle for the deser_queue receiver/queue block.
//   master : the bit source / queue consumer (drives strobes and serial data)
//   slave  : the deser_queue block itself
//
//   data_in        serial bit, sampled on a write_in rising edge
//   write_in       bit strobe
//   enqueue_in     commit held word strobe
//   dequeue_in     pop queue head strobe
//   status_out     receiver accepting bits
//   data_out       queue head (0 when empty)
//   count_out      queue occupancy, 0..DEPTH
//   full_out       queue full
//   empty_out      queue empty
//   overflow_out   one-cycle pulse: commit refused because the queue is full
//   underflow_out  one-cycle pulse: pop requested on an empty queue
//   parity_err_out one-cycle pulse: frame parity mismatch
// -----------------------------------------------------------------------------
interface deser_queue_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             data_in;
    logic             write_in;
    logic             enqueue_in;
    logic             dequeue_in;
    logic             status_out;
    logic [WIDTH-1:0] data_out;
    logic [CW-1:0]    count_out;
    logic             full_out;
    logic             empty_out;
    logic             overflow_out;
    logic             underflow_out;
    logic             parity_err_out;

    modport master (
        output data_in, write_in, enqueue_in, dequeue_in,
        input  status_out, data_out, count_out, full_out, empty_out,
        input  overflow_out, underflow_out, parity_err_out
    );

    modport slave (
        input  data_in, write_in, enqueue_in, dequeue_in,
        output status_out, data_out, count_out, full_out, empty_out,
        output overflow_out, underflow_out, parity_err_out
    );
endinterface

// File: rtl/deser_queue.sv
// -----------------------------------------------------------------------------
// deser_queue
//   Serial-to-parallel receiver feeding a DEPTH-entry circular word queue.
//   Bits arrive one per write_in rising edge and are assembled into a WIDTH-bit
//   word. A complete word is held (status_out low) until it is committed into
//   the queue, either by an enqueue_in rising edge or, with AUTO_ENQ=1, on the
//   first cycle in HOLD where the queue has room. The queue head is presented
//   show-ahead on data_out and popped by a dequeue_in rising edge.
//
//   Parameters
//     WIDTH     data bits per word (>= 2)
//     DEPTH     queue entries (power of 2, >= 2)
//     MSB_FIRST 0: first received bit lands in bit 0; 1: in bit WIDTH-1
//     AUTO_ENQ  1: commit completed words without waiting for enqueue_in
//
//   Ports
//     clock_1MHz  system clock, all state changes on the rising edge
//     rst         asynchronous active-low reset
//     bus         deser_queue_if.slave (strobes, serial data, queue outputs)
//
//   Build option
//     DESER_PARITY_EN  when defined, each frame carries one trailing even
//                      parity bit; a mismatch drops the word and pulses
//                      parity_err_out. Undefined: parity_err_out is tied low.
// -----------------------------------------------------------------------------
module deser_queue #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int MSB_FIRST = 0,
    parameter int AUTO_ENQ  = 0
) (
    input logic         clock_1MHz,
    input logic         rst,
    deser_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
`ifdef DESER_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int BW = $clog2(FRAME + 1);

    typedef enum logic {
        RECV = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                     state;
    logic                       status;
    logic                       write_q;
    logic                       enq_q;
    logic                       deq_q;
    logic [BW-1:0]              bit_cnt;
    logic [WIDTH-1:0]           shreg;
    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [PW-1:0]              rd_ptr;
    logic [PW-1:0]              wr_ptr;
    logic [CW-1:0]              count;
    logic                       overflow;
    logic                       underflow;
    logic                       parity_err;

    logic                       wr_edge;
    logic                       enq_edge;
    logic                       deq_edge;
    logic                       full;
    logic                       empty;
    logic                       pop;
    logic                       push;
    logic                       commit_req;
    logic                       last_bit;
    logic [WIDTH-1:0]           shifted;

    // Strobes act once per rising edge, however long the level is held.
    assign wr_edge  = bus.write_in   & ~write_q;
    assign enq_edge = bus.enqueue_in & ~enq_q;
    assign deq_edge = bus.dequeue_in & ~deq_q;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // LSB-first shifts right so the first bit walks down to bit 0 after
    // WIDTH shifts; MSB-first shifts left so it ends up in bit WIDTH-1.
    assign shifted = (MSB_FIRST != 0) ? {shreg[WIDTH-2:0], bus.data_in}
                                      : {bus.data_in, shreg[WIDTH-1:1]};

    assign last_bit = (bit_cnt == BW'(FRAME - 1));

    // A pop in the same cycle frees a slot, so a commit into a full queue is
    // still allowed when it coincides with a successful dequeue.
    assign pop        = deq_edge & ~empty;
    assign commit_req = (state == HOLD) & ((AUTO_ENQ != 0) ? 1'b1 : enq_edge);
    assign push       = commit_req & (~full | pop);

`ifdef DESER_PARITY_EN
    logic parity_ok;
    // Even parity across the data word plus the trailing parity bit.
    assign parity_ok = ~(^shreg ^ bus.data_in);
`endif

    always_ff @(posedge clock_1MHz or negedge rst) begin
        if (!rst) begin
            state      <= RECV;
            status     <= 1'b1;
            write_q    <= 1'b0;
            enq_q      <= 1'b0;
            deq_q      <= 1'b0;
            bit_cnt    <= '0;
            shreg      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            write_q    <= bus.write_in;
            enq_q      <= bus.enqueue_in;
            deq_q      <= bus.dequeue_in;
            parity_err <= 1'b0;
            // Overflow only exists in manual mode: auto-commit simply waits.
            overflow   <= (AUTO_ENQ == 0) && (state == HOLD) && enq_edge
                          && full && !pop;
            underflow  <= deq_edge & empty;

            case (state)
                RECV: begin
                    if (wr_edge) begin
                        if (last_bit) begin
`ifdef DESER_PARITY_EN
                            // Parity bit is checked, never shifted in.
                            if (parity_ok) begin
                                bit_cnt <= bit_cnt + BW'(1);
                                state   <= HOLD;
                                status  <= 1'b0;
                            end else begin
                                bit_cnt    <= '0;
                                parity_err <= 1'b1;
                            end
`else
                            shreg   <= shifted;
                            bit_cnt <= bit_cnt + BW'(1);
                            state   <= HOLD;
                            status  <= 1'b0;
`endif
                        end else begin
                            shreg   <= shifted;
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (push) begin
                        bit_cnt <= '0;
                        state   <= RECV;
                        status  <= 1'b1;
                    end
                end
                default: begin
                    state  <= RECV;
                    status <= 1'b1;
                end
            endcase

            // Pointers wrap naturally because DEPTH is a power of two.
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    // Storage needs no reset: an entry is only visible once count covers it.
    always_ff @(posedge clock_1MHz) begin
        if (push) mem[wr_ptr] <= shreg;
    end

    assign bus.status_out     = status;
    assign bus.data_out       = empty ? '0 : mem[rd_ptr];
    assign bus.count_out      = count;
    assign bus.full_out       = full;
    assign bus.empty_out      = empty;
    assign bus.overflow_out   = overflow;
    assign bus.underflow_out  = underflow;
`ifdef DESER_PARITY_EN
    assign bus.parity_err_out = parity_err;
`else
    assign bus.parity_err_out = 1'b0;
`endif

endmodule

// File: tb/tb_deser_queue.sv
// -----------------------------------------------------------------------------
// tb_deser_queue
//   Two instances: u_a (WIDTH 8, DEPTH 4, LSB-first, manual commit) and
//   u_b (WIDTH 12, DEPTH 4, MSB-first, auto commit). Directed table for the
//   queue corner cases, hand sequences for multi-cycle timing, and a random
//   phase on u_a checked against a queue-based model.
// -----------------------------------------------------------------------------
module tb_deser_queue;
`ifdef DESER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NBA = 8 + PAR;
    localparam int NBB = 12 + PAR;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    deser_queue_if #(.WIDTH(8),  .DEPTH(4)) ba ();
    deser_queue_if #(.WIDTH(12), .DEPTH(4)) bb ();

    deser_queue #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(0), .AUTO_ENQ(0)) u_a (
        .clock_1MHz(clk), .rst(rst), .bus(ba));
    deser_queue #(.WIDTH(12), .DEPTH(4), .MSB_FIRST(1), .AUTO_ENQ(1)) u_b (
        .clock_1MHz(clk), .rst(rst), .bus(bb));

    int n_chk = 0;
    int n_fail = 0;

    // model of u_a / u_b
    int qa[$];
    int qb[$];
    bit hold_a = 0;
    int cur_a = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic fbit_a(input logic [7:0] w, input int j);
        return (j < 8) ? w[j] : ^w;
    endfunction

    function automatic logic fbit_b(input logic [11:0] w, input int j);
        return (j < 12) ? w[11-j] : ^w;
    endfunction

    task automatic send_bit_a(input logic b, input int hold);
        ba.data_in = b; ba.write_in = 1'b1;
        repeat (hold) @(negedge clk);
        ba.write_in = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_bit_b(input logic b, input int hold);
        bb.data_in = b; bb.write_in = 1'b1;
        repeat (hold) @(negedge clk);
        bb.write_in = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_word_a(input int w, input int hold);
        logic [7:0] wb;
        wb = w[7:0];
        for (int j = 0; j < NBA; j++) send_bit_a(fbit_a(wb, j), hold);
        cur_a = int'(wb); hold_a = 1;
    endtask

    task automatic send_word_b(input int w, input int hold);
        logic [11:0] wb;
        wb = w[11:0];
        for (int j = 0; j < NBB; j++) send_bit_b(fbit_b(wb, j), hold);
    endtask

    // Strobe enq/deq on u_a, holding the level two cycles; returns pulses seen
    // in both cycles plus the model's expectation for the first.
    task automatic strobe_a(input bit e, input bit d,
                            output bit ov, output bit un, output bit ov2, output bit un2,
                            output bit xov, output bit xun);
        bit full, pop, com;
        full = (qa.size() == 4);
        pop  = d && (qa.size() > 0);
        com  = e && hold_a && (!full || pop);
        xov  = e && hold_a && full && !pop;
        xun  = d && (qa.size() == 0);
        ba.enqueue_in = e; ba.dequeue_in = d;
        @(negedge clk);
        ov = ba.overflow_out; un = ba.underflow_out;
        @(negedge clk);
        ov2 = ba.overflow_out; un2 = ba.underflow_out;
        ba.enqueue_in = 1'b0; ba.dequeue_in = 1'b0;
        @(negedge clk);
        if (pop) void'(qa.pop_front());
        if (com) begin qa.push_back(cur_a); hold_a = 0; end
    endtask

    task automatic check_a(input string nm);
        chk({nm, ".status"}, int'(ba.status_out), int'(!hold_a));
        chk({nm, ".count"},  int'(ba.count_out), qa.size());
        chk({nm, ".data"},   int'(ba.data_out), (qa.size() > 0) ? qa[0] : 0);
        chk({nm, ".full"},   int'(ba.full_out), int'(qa.size() == 4));
        chk({nm, ".empty"},  int'(ba.empty_out), int'(qa.size() == 0));
    endtask

    task automatic check_rst(input string nm);
        chk({nm, ".a.status"}, int'(ba.status_out), 1);
        chk({nm, ".a.data"},   int'(ba.data_out), 0);
        chk({nm, ".a.count"},  int'(ba.count_out), 0);
        chk({nm, ".a.empty"},  int'(ba.empty_out), 1);
        chk({nm, ".a.full"},   int'(ba.full_out), 0);
        chk({nm, ".a.ovf"},    int'(ba.overflow_out), 0);
        chk({nm, ".a.unf"},    int'(ba.underflow_out), 0);
        chk({nm, ".a.perr"},   int'(ba.parity_err_out), 0);
        chk({nm, ".b.status"}, int'(bb.status_out), 1);
        chk({nm, ".b.count"},  int'(bb.count_out), 0);
        chk({nm, ".b.data"},   int'(bb.data_out), 0);
    endtask

    typedef struct {
        int word;   // -1: no word sent before the strobe
        int enq, deq;
        int cnt, head, status, ov, un;
    } vec_t;

    initial begin
        vec_t tbl[14];
        bit ov, un, ov2, un2, xov, xun;
        int w;
        logic [11:0] wb;

        tbl[0]  = '{1,     1, 0, 1, 1,     1, 0, 0};
        tbl[1]  = '{2,     1, 0, 2, 1,     1, 0, 0};
        tbl[2]  = '{3,     1, 0, 3, 1,     1, 0, 0};
        tbl[3]  = '{4,     1, 0, 4, 1,     1, 0, 0};
        tbl[4]  = '{5,     1, 0, 4, 1,     0, 1, 0};
        tbl[5]  = '{-1,    1, 1, 4, 2,     1, 0, 0};
        tbl[6]  = '{-1,    0, 1, 3, 3,     1, 0, 0};
        tbl[7]  = '{-1,    0, 1, 2, 4,     1, 0, 0};
        tbl[8]  = '{-1,    0, 1, 1, 5,     1, 0, 0};
        tbl[9]  = '{-1,    0, 1, 0, 0,     1, 0, 0};
        tbl[10] = '{-1,    0, 1, 0, 0,     1, 0, 1};
        tbl[11] = '{'h99,  1, 1, 1, 'h99,  1, 0, 1};
        tbl[12] = '{-1,    0, 1, 0, 0,     1, 0, 0};
        tbl[13] = '{-1,    1, 0, 0, 0,     1, 0, 0};

        ba.data_in = 0; ba.write_in = 0; ba.enqueue_in = 0; ba.dequeue_in = 0;
        bb.data_in = 0; bb.write_in = 0; bb.enqueue_in = 0; bb.dequeue_in = 0;

        // reset values
        repeat (2) @(negedge clk);
        check_rst("reset");
        rst = 1'b1;
        @(negedge clk);

        // basic receive: 8'h99 LSB-first, each bit held 10 cycles
        for (int j = 0; j < NBA - 1; j++) send_bit_a(fbit_a(8'h99, j), 10);
        ba.data_in = fbit_a(8'h99, NBA - 1); ba.write_in = 1'b1;
        chk("basic.status_before_last", int'(ba.status_out), 1);
        @(negedge clk);
        chk("basic.status_after_last", int'(ba.status_out), 0);
        repeat (9) @(negedge clk);
        chk("basic.status_held", int'(ba.status_out), 0);
        ba.write_in = 1'b0;
        @(negedge clk);
        cur_a = 'h99; hold_a = 1;
        strobe_a(1, 0, ov, un, ov2, un2, xov, xun);
        chk("basic.data", int'(ba.data_out), 'h99);
        chk("basic.count", int'(ba.count_out), 1);
        chk("basic.status", int'(ba.status_out), 1);
        strobe_a(0, 1, ov, un, ov2, un2, xov, xun);
        check_a("basic.drain");

        // directed queue table: fill, overflow, commit+pop when full, wrap,
        // underflow, commit+pop when empty, enqueue ignored in RECV
        for (int i = 0; i < 14; i++) begin
            if (tbl[i].word >= 0) send_word_a(tbl[i].word, 1 + (i % 3));
            strobe_a(tbl[i].enq[0], tbl[i].deq[0], ov, un, ov2, un2, xov, xun);
            chk($sformatf("tbl%0d.ovf", i),    int'(ov), tbl[i].ov);
            chk($sformatf("tbl%0d.unf", i),    int'(un), tbl[i].un);
            chk($sformatf("tbl%0d.pulse2", i), int'(ov2 | un2), 0);
            chk($sformatf("tbl%0d.count", i),  int'(ba.count_out), tbl[i].cnt);
            chk($sformatf("tbl%0d.data", i),   int'(ba.data_out), tbl[i].head);
            chk($sformatf("tbl%0d.status", i), int'(ba.status_out), tbl[i].status);
            chk($sformatf("tbl%0d.full", i),   int'(ba.full_out), int'(tbl[i].cnt == 4));
        end

        // reset mid-frame with a word already queued
        send_word_a('h55, 1);
        strobe_a(1, 0, ov, un, ov2, un2, xov, xun);
        for (int j = 0; j < 5; j++) send_bit_a(1'b1, 1);
        rst = 1'b0;
        @(negedge clk);
        check_rst("midrst");
        qa.delete(); hold_a = 0;
        rst = 1'b1;
        @(negedge clk);
        send_word_a('h3C, 2);
        chk("midrst.hold", int'(ba.status_out), 0);
        strobe_a(1, 0, ov, un, ov2, un2, xov, xun);
        chk("midrst.data", int'(ba.data_out), 'h3C);
        chk("midrst.count", int'(ba.count_out), 1);
        strobe_a(0, 1, ov, un, ov2, un2, xov, xun);
        check_a("midrst.drain");

        // random traffic on u_a against the queue model
        for (int it = 0; it < 300; it++) begin
            if (!hold_a && ($urandom_range(0, 1) == 1))
                send_word_a(int'($urandom_range(0, 255)), int'($urandom_range(1, 3)));
            strobe_a($urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0,
                     ov, un, ov2, un2, xov, xun);
            chk("rnd.ovf", int'(ov), int'(xov));
            chk("rnd.unf", int'(un), int'(xun));
            chk("rnd.pulse2", int'(ov2 | un2), 0);
            chk("rnd.perr", int'(ba.parity_err_out), 0);
            check_a("rnd");
        end

        // u_b: MSB-first 12-bit, auto commit one cycle after the final bit
        for (int j = 0; j < NBB - 1; j++) send_bit_b(fbit_b(12'hA03, j), 2);
        bb.data_in = fbit_b(12'hA03, NBB - 1); bb.write_in = 1'b1;
        @(negedge clk);
        chk("auto.status_hold", int'(bb.status_out), 0);
        chk("auto.count_hold", int'(bb.count_out), 0);
        @(negedge clk);
        chk("auto.status", int'(bb.status_out), 1);
        chk("auto.count", int'(bb.count_out), 1);
        chk("auto.data", int'(bb.data_out), 'hA03);
        bb.write_in = 1'b0;
        @(negedge clk);
        qb.push_back('hA03);

        for (int k = 0; k < 3; k++) begin
            w = int'($urandom_range(0, 4095));
            send_word_b(w, 1);
            qb.push_back(w);
        end
        chk("autofull.count", int'(bb.count_out), 4);
        chk("autofull.full", int'(bb.full_out), 1);
        chk("autofull.data", int'(bb.data_out), qb[0]);

        // fifth word waits in HOLD without overflow
        w = int'($urandom_range(0, 4095));
        send_word_b(w, 1);
        for (int k = 0; k < 3; k++) begin
            chk("autowait.status", int'(bb.status_out), 0);
            chk("autowait.ovf", int'(bb.overflow_out), 0);
            chk("autowait.count", int'(bb.count_out), 4);
            @(negedge clk);
        end
        bb.dequeue_in = 1'b1;
        @(negedge clk);
        chk("autopop.count", int'(bb.count_out), 4);
        chk("autopop.status", int'(bb.status_out), 1);
        chk("autopop.data", int'(bb.data_out), qb[1]);
        chk("autopop.unf", int'(bb.underflow_out), 0);
        bb.dequeue_in = 1'b0;
        @(negedge clk);
        void'(qb.pop_front());
        qb.push_back(w);

        for (int k = 0; k < 4; k++) begin
            chk("bdrain.data", int'(bb.data_out), qb[0]);
            bb.dequeue_in = 1'b1;
            @(negedge clk);
            bb.dequeue_in = 1'b0;
            @(negedge clk);
            void'(qb.pop_front());
            chk("bdrain.count", int'(bb.count_out), qb.size());
        end
        chk("bdrain.empty_data", int'(bb.data_out), 0);

`ifdef DESER_PARITY_EN
        // good parity commits, bad parity drops the word with a pulse
        send_word_b('h099, 1);
        chk("par.good.count", int'(bb.count_out), 1);
        chk("par.good.data", int'(bb.data_out), 'h099);
        wb = 12'h099;
        for (int j = 0; j < 12; j++) send_bit_b(fbit_b(wb, j), 1);
        bb.data_in = ~(^wb); bb.write_in = 1'b1;
        @(negedge clk);
        chk("par.bad.perr", int'(bb.parity_err_out), 1);
        chk("par.bad.status", int'(bb.status_out), 1);
        @(negedge clk);
        chk("par.bad.perr_clear", int'(bb.parity_err_out), 0);
        chk("par.bad.count", int'(bb.count_out), 1);
        bb.write_in = 1'b0;
        @(negedge clk);
`else
        wb = 12'h0;
        chk("nopar.perr", int'(bb.parity_err_out) | int'(wb[0]), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
